bus_wrr_sched: RTL and testbench

Weighted round-robin scheduler that sequences the shared packet bus between `drvrs` device FIFOs. It watches each device's pending flag and grants exactly one device at a time. For the granted device it pops the head packet, decodes the destination ID in the packet's top 8 bits, and pushes the packet to the destination device, or to every other device on broadcast. It sits between the device FIFOs and the bus fabric, in the same slot as the bus generator/arbiter, and uses the same pndng/pop/push/D_pop/D_push port vocabulary.

---
 rtl/bus_sched_pkg.sv | 27 ++
 rtl/rr_pick.sv | 34 +++
 rtl/bus_wrr_sched.sv | 152 +++++++++++++++
 tb/tb_bus_wrr_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_sched_pkg : shared types and helpers for the bus WRR scheduler   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    ROUTE = 2'd2,
    PUSH  = 2'd3
  } sched_state_t;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 256;

  // Packet is passed zero-extended so one function serves every pckg_sz.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned         pkt_w);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : first set request at or after start, wrapping N-1 -> 0     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N  = 5,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  localparam logic [IW-1:0] c_LAST = IW'(N - 1);

  logic [IW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = start_i;
    for (int k = 0; k < N; k++) begin
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
      cand = (cand == c_LAST) ? '0 : cand + IW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_wrr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_wrr_sched : weighted round-robin packet bus scheduler            |
// | Optional broadcast delivery enabled by defining BUS_BCAST_EN.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bus_wrr_sched
  import bus_sched_pkg::*;
#(
  parameter int              drvrs     = 5,
  parameter int              pckg_sz   = 32,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int              WGT_W     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [drvrs-1:0]                 pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
  input  logic [drvrs-1:0][WGT_W-1:0]      cfg_weight,
  output logic [drvrs-1:0]                 pop,
  output logic [drvrs-1:0]                 push,
  output logic [pckg_sz-1:0]               D_push,
  output logic [$clog2(drvrs)-1:0]         grant_id,
  output logic                             busy,
  output logic                             drop
);

  localparam int               IW     = $clog2(drvrs);
  localparam logic [IW-1:0]    c_LAST = IW'(drvrs - 1);
  localparam logic [drvrs-1:0] c_ONE  = drvrs'(1);
  localparam logic [WGT_W-1:0] c_W1   = WGT_W'(1);

  sched_state_t        state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d, grant_q, grant_d, src_q, src_d;
  logic [WGT_W-1:0]    credit_q, credit_d;
  logic [pckg_sz-1:0]  pkt_q, pkt_d, dpush_q, dpush_d;
  logic [drvrs-1:0]    pop_q, pop_d, push_q, push_d, mask;
  logic                busy_q, busy_d, drop_q, drop_d, bad_dest;
  logic [IW-1:0]       start_w, pick_idx;
  logic                pick_found, keep;
  logic [ID_W-1:0]     dest;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (i == c_LAST) ? '0 : i + IW'(1);
  endfunction

  // Owner keeps the bus while it has credit and data; losing either moves the search past it.
  assign keep    = (credit_q != '0) && pndng[grant_q];
  assign start_w = (credit_q != '0) ? wrap_inc(grant_q) : ptr_q;

  rr_pick #(.N(drvrs), .IW(IW)) u_pick (
    .req_i   (pndng),
    .start_i (start_w),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign dest = get_dest(PKT_MAX_W'(pkt_q), pckg_sz);

  always_comb begin
    mask     = '0;
    bad_dest = 1'b0;
`ifdef BUS_BCAST_EN
    if (int'(dest) < drvrs)  mask = c_ONE << dest;
    else if (dest == broadcast) mask = ~(c_ONE << src_q);
    else                     bad_dest = 1'b1;
`else
    // The broadcast term folds away whenever the ID lies outside the device range.
    if (int'(dest) < drvrs && dest != broadcast) mask = c_ONE << dest;
    else                                         bad_dest = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    grant_d  = grant_q;
    src_d    = src_q;
    pkt_d    = pkt_q;
    dpush_d  = dpush_q;
    pop_d    = '0;
    push_d   = '0;
    drop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = POP;
          if (!keep) begin
            grant_d  = pick_idx;
            ptr_d    = start_w;
            credit_d = (cfg_weight[pick_idx] == '0) ? c_W1 : cfg_weight[pick_idx];
          end
          pop_d = c_ONE << grant_d;
        end
      end
      POP: begin
        pkt_d    = D_pop[grant_q];
        src_d    = grant_q;
        credit_d = (credit_q == '0) ? '0 : credit_q - c_W1;
        if (credit_q <= c_W1) ptr_d = wrap_inc(grant_q);
        state_d  = ROUTE;
      end
      ROUTE: begin
        push_d  = mask;
        dpush_d = pkt_q;
        drop_d  = bad_dest;
        state_d = PUSH;
      end
      PUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      credit_q <= '0;
      grant_q  <= '0;
      src_q    <= '0;
      pkt_q    <= '0;
      dpush_q  <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      grant_q  <= grant_d;
      src_q    <= src_d;
      pkt_q    <= pkt_d;
      dpush_q  <= dpush_d;
      pop_q    <= pop_d;
      push_q   <= push_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign drop     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_wrr_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_wrr_sched : directed + random bench with FIFO and grant model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bus_wrr_sched;

  localparam int N  = 5;
  localparam int PW = 32;
  localparam int WW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         pndng;
  logic [N-1:0][PW-1:0] D_pop;
  logic [N-1:0][WW-1:0] cfg_weight;
  logic [N-1:0]         pop, push;
  logic [PW-1:0]        D_push;
  logic [2:0]           grant_id;
  logic                 busy, drop;

  always #5 clk = ~clk;

  bus_wrr_sched #(.drvrs(N), .pckg_sz(PW), .broadcast(8'hFF), .WGT_W(WW)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .cfg_weight(cfg_weight),
    .pop(pop), .push(push), .D_push(D_push), .grant_id(grant_id), .busy(busy), .drop(drop)
  );

  logic [PW-1:0] fifo [N][$];
  int n_assert = 0, n_fail = 0, cyc = 0;
  int m_last = 0, m_rem = 0, m_next = 0, idle_from = 0;
  int exp_cyc = -1;
  logic [N-1:0]  pop_pend = '0, exp_push;
  logic          exp_drop;
  logic [PW-1:0] exp_data;
  int grants[$], pop_cycs[$];
  int push_cnt, drop_cnt, last_push_cyc;
  logic [N-1:0]  last_push;
  logic [PW-1:0] last_dpush;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (fifo[i].size() > 0);
      D_pop[i] = (fifo[i].size() > 0) ? fifo[i][0] : '0;
    end
  endtask

  // Destination rule: {drop, push mask} for a packet from device src.
  function automatic logic [N:0] route(input logic [PW-1:0] pkt, input int src);
    int d; logic [N-1:0] m; logic dr;
    d = int'(pkt[PW-1 -: 8]); m = '0; dr = 1'b0;
    if (d < N) m[d] = 1'b1;
    else if (d == 255) begin
`ifdef BUS_BCAST_EN
      for (int i = 0; i < N; i++) m[i] = (i != src);
`else
      dr = (src >= 0);
`endif
    end else dr = 1'b1;
    return {dr, m};
  endfunction

  // Weighted round robin: owner keeps bus for weight grants while pending.
  function automatic int model_pick(input logic [N-1:0] pend);
    int w;
    if (m_rem > 0 && pend[m_last]) w = m_last;
    else begin
      if (m_rem > 0) m_next = (m_last + 1) % N;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && pend[(m_next + k) % N]) w = (m_next + k) % N;
      m_rem = (cfg_weight[w] == 0) ? 1 : int'(cfg_weight[w]);
    end
    m_rem--;
    if (m_rem == 0) m_next = (w + 1) % N;
    m_last = w;
    return w;
  endfunction

  task automatic step();
    logic [N-1:0] pend_at_edge, exp_pop;
    logic rst_at_edge;
    int win;
    pend_at_edge = pndng;
    rst_at_edge  = reset;
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < N; i++)
      if (pop_pend[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    if (rst_at_edge) begin
      chk("rst_pop", pop, 0);  chk("rst_push", push, 0);  chk("rst_dpush", D_push, 0);
      chk("rst_grant", grant_id, 0); chk("rst_busy", busy, 0); chk("rst_drop", drop, 0);
      m_last = 0; m_rem = 0; m_next = 0; idle_from = cyc + 1; exp_cyc = -1;
    end else begin
      exp_pop = '0;
      if (cyc >= idle_from && pend_at_edge != 0) begin
        win = model_pick(pend_at_edge);
        exp_pop[win] = 1'b1;
        exp_data = (fifo[win].size() > 0) ? fifo[win][0] : '0;
        {exp_drop, exp_push} = route(exp_data, win);
        exp_cyc = cyc + 2; idle_from = cyc + 4;
        grants.push_back(win); pop_cycs.push_back(cyc);
        chk("grant_id", grant_id, win);
      end
      chk("pop", pop, exp_pop);
      chk("busy", busy, cyc < idle_from - 1);
      if (cyc == exp_cyc) begin
        chk("push", push, exp_push);
        chk("drop", drop, exp_drop);
        if (exp_push != 0) chk("D_push", D_push, exp_data);
      end else begin
        chk("push_quiet", push, 0);
        chk("drop_quiet", drop, 0);
      end
    end
    if (push != 0) begin
      push_cnt++; last_push = push; last_dpush = D_push; last_push_cyc = cyc;
    end
    if (drop) drop_cnt++;
    pop_pend = pop;
    drive_inputs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (fifo[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_drain(input int budget);
    bit done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      step();
      done = all_empty() && (cyc >= idle_from);
    end
    chk("drain_in_budget", done, 1);
  endtask

  task automatic clear_obs();
    grants.delete(); pop_cycs.delete();
    push_cnt = 0; drop_cnt = 0; last_push = '0; last_dpush = '0; last_push_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0] d; int sel;
    sel = $urandom_range(0, 9);
    if (sel < 5)       d = 8'(sel);
    else if (sel < 7)  d = 8'hFF;
    else if (sel == 7) d = 8'h07;
    else               d = 8'($urandom_range(5, 254));
    return {d, 24'($urandom)};
  endfunction

  initial begin
    int rr_exp[6] = '{0, 1, 2, 3, 4, 0};
    int wt_exp[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
    int rel;
    bit seen;
    for (int i = 0; i < N; i++) cfg_weight[i] = WW'(1);
    clear_obs();

    // Reset with every device pending, then round robin over the backlog.
    reset = 1'b1;
    fifo[0].push_back(32'h0100_0000); fifo[0].push_back(32'h0200_0001);
    for (int i = 1; i < N; i++) fifo[i].push_back({8'((i + 1) % N), 24'(i)});
    drive_inputs();
    step(); step();
    reset = 1'b0; rel = cyc;
    run_drain(80);
    chk("rst_first_pop_cyc", (pop_cycs.size() > 0) ? pop_cycs[0] : -1, rel + 1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_grant%0d", i), (grants.size() > i) ? grants[i] : -1, rr_exp[i]);
    for (int i = 1; i < 6; i++)
      chk($sformatf("rr_gap%0d", i), (pop_cycs.size() > i) ? pop_cycs[i] - pop_cycs[i-1] : -1, 4);

    // Unicast to device 3.
    clear_obs();
    fifo[0].push_back(32'h0300_00AA); drive_inputs();
    run_drain(20);
    chk("uni_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    chk("uni_push", last_push, 5'b01000);
    chk("uni_data", last_dpush, 32'h0300_00AA);
    chk("uni_latency", last_push_cyc - ((pop_cycs.size() > 0) ? pop_cycs[0] : 0), 2);

    // Weighting 3:1 between devices 1 and 2.
    do_reset(); clear_obs();
    cfg_weight[1] = WW'(3);
    for (int i = 0; i < 6; i++) fifo[1].push_back({8'd0, 24'(i)});
    for (int i = 0; i < 2; i++) fifo[2].push_back({8'd4, 24'(i)});
    drive_inputs();
    run_drain(100);
    for (int i = 0; i < 8; i++)
      chk($sformatf("wt_grant%0d", i), (grants.size() > i) ? grants[i] : -1, wt_exp[i]);
    cfg_weight[1] = WW'(1);

    // Broadcast from device 2.
    clear_obs();
    fifo[2].push_back(32'hFF00_1234); drive_inputs();
    run_drain(20);
`ifdef BUS_BCAST_EN
    chk("bcast_push", last_push, 5'b11011);
    chk("bcast_nodrop", drop_cnt, 0);
`else
    chk("bcast_nopush", push_cnt, 0);
    chk("bcast_drop", drop_cnt, 1);
`endif

    // Out-of-range destination.
    clear_obs();
    fifo[3].push_back(32'h0700_0055); drive_inputs();
    run_drain(20);
    chk("inv_nopush", push_cnt, 0);
    chk("inv_drop", drop_cnt, 1);

    // Reset while the popped packet sits in ROUTE.
    do_reset(); clear_obs();
    fifo[0].push_back(32'h0100_BEEF); drive_inputs();
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin step(); seen = (pop != 0); end
    chk("mid_pop_seen", seen, 1);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    for (int t = 0; t < 6; t++) step();
    chk("mid_nopush", push_cnt, 0);
    chk("mid_nodrop", drop_cnt, 0);
    chk("mid_consumed", fifo[0].size(), 0);

    // Random traffic with random weights, including weight 0.
    do_reset(); clear_obs();
    for (int i = 0; i < N; i++) cfg_weight[i] = WW'($urandom_range(0, 3));
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int dv = $urandom_range(0, N - 1);
        if (fifo[dv].size() < 8) fifo[dv].push_back(rand_pkt());
      end
      drive_inputs();
      step();
    end
    run_drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
